// File: rtl/axi3_burst_addr_gen.sv
// AXI3 burst address generator.
// Accepts one AR/AW-style burst command and expands it into len+1 per-beat
// addresses (FIXED / INCR / WRAP), flagging illegal commands with beat_err.
// A new command may be accepted on the cycle the last beat transfers, so
// consecutive bursts run without an idle cycle.
module axi3_burst_addr_gen #(
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int DATA_BYTES_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  // Command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [3:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  // Per-beat address channel
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [ID_WIDTH-1:0]   beat_id,
  output logic [3:0]            beat_idx,
  output logic                  beat_last,
  output logic                  beat_err
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] BURST_RSVD = 2'b11;

  localparam logic [2:0]            MAX_SIZE = 3'(DATA_BYTES_LOG2);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ID_WIDTH-1:0]   r_id;
  logic [3:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [3:0]            r_idx;
  logic                  r_err;

  logic                  w_xfer;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_cmd_bytes;
  logic [ADDR_WIDTH-1:0] w_cmd_aligned;
  logic [ADDR_WIDTH-1:0] w_cmd_last_addr;
  logic                  w_wrap_len_ok;
  logic                  w_cmd_err;
  logic [ADDR_WIDTH-1:0] w_beat_bytes;
  logic [ADDR_WIDTH-1:0] w_wrap_mask;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  // Handshakes; cmd_ready looks through to beat_ready so the next command
  // can be taken on the same edge that retires the last beat.
  assign beat_valid = (r_state == S_BURST);
  assign beat_last  = beat_valid && (r_idx == r_len);
  assign w_xfer     = beat_valid && beat_ready;
  assign cmd_ready  = (r_state == S_IDLE) || (w_xfer && beat_last);
  assign w_accept   = cmd_valid && cmd_ready;

  assign beat_addr = r_addr;
  assign beat_id   = r_id;
  assign beat_idx  = r_idx;
  assign beat_err  = r_err;

  // Legality of the incoming command, evaluated once at acceptance.
  // The 4 KB check uses the aligned start plus len beats, i.e. the address
  // of the final INCR beat.
  assign w_cmd_bytes     = ONE << cmd_size;
  assign w_cmd_aligned   = cmd_addr & ~(w_cmd_bytes - ONE);
  assign w_cmd_last_addr = w_cmd_aligned + (ADDR_WIDTH'(cmd_len) << cmd_size);
  assign w_wrap_len_ok   = (cmd_len == 4'd1) || (cmd_len == 4'd3) ||
                           (cmd_len == 4'd7) || (cmd_len == 4'd15);
  assign w_cmd_err = (cmd_burst == BURST_RSVD) ||
                     (cmd_size > MAX_SIZE) ||
                     ((cmd_burst == BURST_WRAP) && !w_wrap_len_ok) ||
                     ((cmd_burst == BURST_WRAP) && ((cmd_addr & (w_cmd_bytes - ONE)) != '0)) ||
                     ((cmd_burst == BURST_INCR) &&
                      (w_cmd_last_addr[ADDR_WIDTH-1:12] != cmd_addr[ADDR_WIDTH-1:12]));

  // Wrap window is (len+1) beats; since the current address always lies
  // inside it, the boundary can be recovered from the current address.
  assign w_beat_bytes = ONE << r_size;
  assign w_wrap_mask  = ((ADDR_WIDTH'(r_len) + ONE) << r_size) - ONE;

  // Address of the following beat; FIXED and reserved bursts repeat.
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    w_next_addr = r_addr;
    case (r_burst)
      BURST_INCR: w_next_addr = (r_addr & ~(w_beat_bytes - ONE)) + w_beat_bytes;
      BURST_WRAP: w_next_addr = (r_addr & ~w_wrap_mask) |
                                ((r_addr + w_beat_bytes) & w_wrap_mask);
      default:    w_next_addr = r_addr;
    endcase
  end

  // Burst state: load on acceptance, advance on each non-final transfer,
  // fall back to IDLE after the final transfer unless a new command loads.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_id    <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_state <= S_BURST;
      r_addr  <= cmd_addr;
      r_id    <= cmd_id;
      r_len   <= cmd_len;
      r_size  <= cmd_size;
      r_burst <= cmd_burst;
      r_idx   <= '0;
      r_err   <= w_cmd_err;
    end else if (w_xfer) begin
      if (beat_last) begin
        r_state <= S_IDLE;
      end else begin
        r_addr <= w_next_addr;
        r_idx  <= r_idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi3_burst_addr_gen.sv
// Self-checking bench for axi3_burst_addr_gen: directed commands push their
// expected beats into a scoreboard queue; a monitor pops and compares on
// every beat transfer. Scenario tasks add inline checks for reset, latency,
// backpressure hold and gap-free back-to-back bursts.
module tb_axi3_burst_addr_gen;

  localparam int AW = 32;
  localparam int IW = 4;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [IW-1:0] cmd_id;
  logic [AW-1:0] cmd_addr;
  logic [3:0]    cmd_len;
  logic [2:0]    cmd_size;
  logic [1:0]    cmd_burst;
  logic          beat_valid;
  logic          beat_ready;
  logic [AW-1:0] beat_addr;
  logic [IW-1:0] beat_id;
  logic [3:0]    beat_idx;
  logic          beat_last;
  logic          beat_err;

  typedef struct {
    logic [AW-1:0] addr;
    logic          chk_addr;
    logic [IW-1:0] id;
    logic [3:0]    idx;
    logic          last;
    logic          err;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    checks = 0;
  int    errors = 0;

  axi3_burst_addr_gen #(
    .ADDR_WIDTH      (AW),
    .ID_WIDTH        (IW),
    .DATA_BYTES_LOG2 (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_id     (cmd_id),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_size   (cmd_size),
    .cmd_burst  (cmd_burst),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_addr  (beat_addr),
    .beat_id    (beat_id),
    .beat_idx   (beat_idx),
    .beat_last  (beat_last),
    .beat_err   (beat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every transferred beat must match the queue head.
  always @(negedge clk) begin
    if (!rst && beat_valid && beat_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got addr=%h id=%0d idx=%0d last=%0b err=%0b, expected no beat",
                 beat_addr, beat_id, beat_idx, beat_last, beat_err);
      end else begin
        mon_e = exp_q.pop_front();
        if ((mon_e.chk_addr && (beat_addr !== mon_e.addr)) || (beat_id !== mon_e.id) ||
            (beat_idx !== mon_e.idx) || (beat_last !== mon_e.last) || (beat_err !== mon_e.err)) begin
          errors++;
          $display("FAIL beat: got addr=%h id=%0d idx=%0d last=%0b err=%0b, expected addr=%h(chk=%0b) id=%0d idx=%0d last=%0b err=%0b",
                   beat_addr, beat_id, beat_idx, beat_last, beat_err,
                   mon_e.addr, mon_e.chk_addr, mon_e.id, mon_e.idx, mon_e.last, mon_e.err);
        end
      end
    end
  end

  task automatic exp_beat(input logic [AW-1:0] addr, input logic chk, input logic [IW-1:0] id,
                          input logic [3:0] idx, input logic last, input logic err);
    beat_t b;
    b.addr = addr; b.chk_addr = chk; b.id = id; b.idx = idx; b.last = last; b.err = err;
    exp_q.push_back(b);
  endtask

  // Present a command and hold it until accepted; afterwards scramble the
  // cmd_* inputs, which must not affect the running burst.
  task automatic send_cmd(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    logic acc;
    logic done;
    done      = 1'b0;
    cmd_id    = id;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_size  = size;
    cmd_burst = burst;
    cmd_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      if (acc) done = 1'b1;
    end
    cmd_valid = 1'b0;
    cmd_id    = IW'($urandom);
    cmd_addr  = $urandom;
    cmd_len   = 4'($urandom);
    cmd_size  = 3'($urandom);
    cmd_burst = 2'($urandom);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout: got no acceptance in 50 cycles, expected acceptance");
    end
  endtask

  // Wait until every expected beat is consumed and the block is idle.
  task automatic wait_drain(input string name);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      if (exp_q.size() == 0 && !beat_valid) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: got %0d beats outstanding, beat_valid=%0b, expected 0 outstanding and idle",
               name, exp_q.size(), beat_valid);
    end
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_id     = '0;
    cmd_addr   = '0;
    cmd_len    = '0;
    cmd_size   = '0;
    cmd_burst  = '0;
    beat_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (beat_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b, expected 0", beat_valid); end
    checks++; if (beat_addr !== '0)    begin errors++; $display("FAIL rst_addr: got %h, expected 0", beat_addr); end
    checks++; if (beat_id !== '0)      begin errors++; $display("FAIL rst_id: got %0d, expected 0", beat_id); end
    checks++; if (beat_idx !== 4'd0)   begin errors++; $display("FAIL rst_idx: got %0d, expected 0", beat_idx); end
    checks++; if (beat_last !== 1'b0)  begin errors++; $display("FAIL rst_last: got %0b, expected 0", beat_last); end
    checks++; if (beat_err !== 1'b0)   begin errors++; $display("FAIL rst_err: got %0b, expected 0", beat_err); end
    checks++; if (cmd_ready !== 1'b1)  begin errors++; $display("FAIL rst_cmd_ready: got %0b, expected 1", cmd_ready); end
    @(posedge clk);
    #1;
    rst        = 1'b0;
    beat_ready = 1'b1;
  endtask

  task automatic test_incr;
    exp_beat(32'h1000, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0);
    exp_beat(32'h1004, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0);
    exp_beat(32'h1008, 1'b1, 4'd1, 4'd2, 1'b0, 1'b0);
    exp_beat(32'h100C, 1'b1, 4'd1, 4'd3, 1'b1, 1'b0);
    send_cmd(4'd1, 32'h1000, 4'd3, 3'd2, 2'b01);
    checks++;
    if (beat_valid !== 1'b1 || beat_idx !== 4'd0) begin
      errors++;
      $display("FAIL incr_latency: got valid=%0b idx=%0d one cycle after accept, expected valid=1 idx=0",
               beat_valid, beat_idx);
    end
    wait_drain("incr");
  endtask

  task automatic test_wrap;
    exp_beat(32'h1008, 1'b1, 4'd2, 4'd0, 1'b0, 1'b0);
    exp_beat(32'h100C, 1'b1, 4'd2, 4'd1, 1'b0, 1'b0);
    exp_beat(32'h1000, 1'b1, 4'd2, 4'd2, 1'b0, 1'b0);
    exp_beat(32'h1004, 1'b1, 4'd2, 4'd3, 1'b1, 1'b0);
    send_cmd(4'd2, 32'h1008, 4'd3, 3'd2, 2'b10);
    wait_drain("wrap");
  endtask

  task automatic test_unaligned;
    exp_beat(32'h1003, 1'b1, 4'd3, 4'd0, 1'b0, 1'b0);
    exp_beat(32'h1004, 1'b1, 4'd3, 4'd1, 1'b1, 1'b0);
    send_cmd(4'd3, 32'h1003, 4'd1, 3'd2, 2'b01);
    wait_drain("unaligned");
  endtask

  task automatic test_fixed;
    for (int i = 0; i < 3; i++) exp_beat(32'h2004, 1'b1, 4'd4, 4'(i), (i == 2), 1'b0);
    send_cmd(4'd4, 32'h2004, 4'd2, 3'd2, 2'b00);
    wait_drain("fixed");
    // Single-beat command: last on beat 0.
    exp_beat(32'h2100, 1'b1, 4'd7, 4'd0, 1'b1, 1'b0);
    send_cmd(4'd7, 32'h2100, 4'd0, 3'd3, 2'b01);
    wait_drain("len0");
  endtask

  task automatic test_errors;
    // INCR crossing 4 KB
    exp_beat(32'h0FF8, 1'b1, 4'd8, 4'd0, 1'b0, 1'b1);
    exp_beat(32'h1000, 1'b1, 4'd8, 4'd1, 1'b1, 1'b1);
    send_cmd(4'd8, 32'h0FF8, 4'd1, 3'd3, 2'b01);
    wait_drain("err_4k");
    // WRAP with illegal length 2: three beats, addresses unconstrained
    for (int i = 0; i < 3; i++) exp_beat('0, 1'b0, 4'd9, 4'(i), (i == 2), 1'b1);
    send_cmd(4'd9, 32'h2000, 4'd2, 3'd2, 2'b10);
    wait_drain("err_wrap_len");
    // Reserved burst type addresses as FIXED
    for (int i = 0; i < 3; i++) exp_beat(32'h2004, 1'b1, 4'd10, 4'(i), (i == 2), 1'b1);
    send_cmd(4'd10, 32'h2004, 4'd2, 3'd2, 2'b11);
    wait_drain("err_rsvd");
    // Size wider than the data bus
    exp_beat(32'h7000, 1'b1, 4'd11, 4'd0, 1'b1, 1'b1);
    send_cmd(4'd11, 32'h7000, 4'd0, 3'd4, 2'b01);
    wait_drain("err_size");
    // WRAP start not aligned to the beat size
    exp_beat(32'h3002, 1'b0, 4'd12, 4'd0, 1'b0, 1'b1);
    exp_beat(32'h0,    1'b0, 4'd12, 4'd1, 1'b1, 1'b1);
    send_cmd(4'd12, 32'h3002, 4'd1, 3'd2, 2'b10);
    wait_drain("err_wrap_align");
  endtask

  task automatic test_back_to_back;
    exp_beat(32'h3000, 1'b1, 4'd5, 4'd0, 1'b0, 1'b0);
    exp_beat(32'h3004, 1'b1, 4'd5, 4'd1, 1'b1, 1'b0);
    exp_beat(32'h4000, 1'b1, 4'd6, 4'd0, 1'b0, 1'b0);
    exp_beat(32'h4008, 1'b1, 4'd6, 4'd1, 1'b1, 1'b0);
    beat_ready = 1'b1;
    cmd_id = 4'd5; cmd_addr = 32'h3000; cmd_len = 4'd1; cmd_size = 3'd2; cmd_burst = 2'b01;
    cmd_valid = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready: got %0b, expected 1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    // Last beat of A is up; offer B while stalling.
    cmd_id = 4'd6; cmd_addr = 32'h4000; cmd_len = 4'd1; cmd_size = 3'd3; cmd_burst = 2'b01;
    cmd_valid  = 1'b1;
    beat_ready = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready: got %0b, expected 0", cmd_ready); end
    @(posedge clk); #1;
    checks++;
    if (beat_valid !== 1'b1 || beat_addr !== 32'h3004 || beat_idx !== 4'd1 || beat_last !== 1'b1 || beat_id !== 4'd5) begin
      errors++;
      $display("FAIL b2b_hold: got valid=%0b addr=%h idx=%0d last=%0b id=%0d, expected 1 00003004 1 1 5",
               beat_valid, beat_addr, beat_idx, beat_last, beat_id);
    end
    beat_ready = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_last_ready: got %0b, expected 1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (beat_valid !== 1'b1 || beat_addr !== 32'h4000 || beat_idx !== 4'd0 || beat_id !== 4'd6) begin
      errors++;
      $display("FAIL b2b_no_gap: got valid=%0b addr=%h idx=%0d id=%0d, expected 1 00004000 0 6",
               beat_valid, beat_addr, beat_idx, beat_id);
    end
    wait_drain("b2b");
  endtask

  task automatic test_reset_mid_burst;
    logic found;
    logic stray;
    found = 1'b0;
    stray = 1'b0;
    exp_beat(32'h5000, 1'b1, 4'd3, 4'd0, 1'b0, 1'b0);
    exp_beat(32'h5004, 1'b1, 4'd3, 4'd1, 1'b0, 1'b0);
    beat_ready = 1'b1;
    send_cmd(4'd3, 32'h5000, 4'd7, 3'd2, 2'b01);
    for (int n = 0; n < 20 && !found; n++) begin
      if (beat_valid && beat_idx == 4'd2) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rst_mid_reach_beat2: got idx=%0d valid=%0b, expected beat 2 presented", beat_idx, beat_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (beat_valid !== 1'b0 || cmd_ready !== 1'b1 || beat_idx !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid_abort: got valid=%0b cmd_ready=%0b idx=%0d, expected 0 1 0",
               beat_valid, cmd_ready, beat_idx);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (beat_valid !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_no_resume: got stray_beat=%0b outstanding=%0d, expected 0 0", stray, exp_q.size());
    end
    exp_beat(32'h6000, 1'b1, 4'd4, 4'd0, 1'b1, 1'b0);
    send_cmd(4'd4, 32'h6000, 4'd0, 3'd2, 2'b01);
    wait_drain("rst_mid_next");
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_unaligned();
    test_fixed();
    test_errors();
    test_back_to_back();
    test_reset_mid_burst();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi3_burst_addr_gen.md
AXI3_BURST_ADDR_GEN -- requirements
Module: axi3_burst_addr_gen

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, giving the address width in bits, legal range 13..64.
REQ-002 The block SHALL have parameter ID_WIDTH, default 4, giving the transaction ID width in bits.
REQ-003 The block SHALL have parameter DATA_BYTES_LOG2, default 3, giving log2 of the data bus width in bytes.

Ports (name, direction, width, meaning):
REQ-004 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 cmd_valid  in  1  burst command (AR/AW channel) valid.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-008 cmd_id  in  ID_WIDTH  transaction ID.
REQ-009 cmd_addr  in  ADDR_WIDTH  start address.
REQ-010 cmd_len  in  4  AXI3 burst length; beats = cmd_len+1.
REQ-011 cmd_size  in  3  burst size, 3-bit AXI3 encoding; bytes per beat = 2^cmd_size.
REQ-012 cmd_burst  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-013 beat_valid  out  1  per-beat address valid.
REQ-014 beat_ready  in  1  downstream accepts the beat.
REQ-015 beat_addr  out  ADDR_WIDTH  byte address of the current beat.
REQ-016 beat_id  out  ID_WIDTH  ID of the owning command.
REQ-017 beat_idx  out  4  beat number within the burst, 0-based.
REQ-018 beat_last  out  1  high on the final beat.
REQ-019 beat_err  out  1  command illegal; the slave answers SLVERR for every beat.

Function
REQ-020 The block SHALL have two states, IDLE and BURST.
REQ-021 cmd_ready SHALL equal (state==IDLE) OR (beat_valid AND beat_ready AND beat_last); this is combinational on beat_ready.
REQ-022 On command acceptance the block SHALL enter BURST, register id/len/size/burst/err, and present beat 0 with beat_valid=1 on the next cycle (1-cycle latency).
REQ-023 Outputs beat_addr, beat_idx, beat_last, beat_id and beat_err SHALL hold stable while beat_valid=1 and beat_ready=0.
REQ-024 On a beat transfer (beat_valid AND beat_ready) with beat_last=0, the block SHALL advance to the next beat and increment beat_idx.
REQ-025 On a beat transfer with beat_last=1, the block SHALL:
- return to IDLE and drop beat_valid if no command is accepted in the same cycle;
- otherwise load the new command and present its beat 0 on the next cycle, with no idle cycle.
REQ-026 beat_last SHALL be 1 exactly when beat_idx == registered len; a len=0 command is a single beat with beat_last=1.
REQ-027 Beat 0 address SHALL be cmd_addr unmodified, including unaligned addresses.
REQ-028 FIXED bursts SHALL repeat the beat 0 address on every beat.
REQ-029 INCR bursts SHALL compute next address = (addr with low cmd_size bits cleared) + 2^cmd_size, modulo 2^ADDR_WIDTH.
REQ-030 WRAP bursts SHALL use wrap_bytes = (len+1)*2^size and boundary = cmd_addr with low log2(wrap_bytes) bits cleared; next address = boundary OR ((addr + 2^size) mod wrap_bytes).
REQ-031 beat_err SHALL be set at acceptance if any of the following holds:
- cmd_burst==11;
- cmd_size > DATA_BYTES_LOG2;
- WRAP with len not in {1,3,7,15};
- WRAP with cmd_addr not aligned to 2^size;
- INCR whose last-beat address differs from cmd_addr in bit 12 or above (4 KB crossing).
REQ-032 Erroneous commands SHALL still produce len+1 beats so the data channel stays aligned; reserved bursts SHALL address as FIXED; beat_err SHALL be constant for the whole burst.
REQ-033 cmd_* inputs SHALL be sampled only on acceptance; changes at other times SHALL have no effect.

Reset
REQ-034 While rst=1, state SHALL be IDLE, beat_valid=0, beat_addr=0, beat_id=0, beat_idx=0, beat_last=0, beat_err=0, and cmd_ready=1.
REQ-035 Reset asserted mid-burst SHALL abort the burst immediately; no further beats of it SHALL appear after reset is released.

Verification
REQ-036 INCR, addr 0x1000, size 2, len 3 -> beat_addr 0x1000, 0x1004, 0x1008, 0x100C; beat_last on idx 3; err 0.
REQ-037 WRAP, addr 0x1008, size 2, len 3 -> 0x1008, 0x100C, 0x1000, 0x1004; err 0.
REQ-038 INCR unaligned, addr 0x1003, size 2, len 1 -> 0x1003, 0x1004.
REQ-039 INCR, addr 0x0FF8, size 3, len 1 -> 0x0FF8, 0x1000 with err 1 on both; WRAP len 2 -> 3 beats, err 1.
REQ-040 Back-to-back and backpressure: second command presented during the last beat, with beat_ready toggling 1,0,1 -> no gap cycle between bursts and addresses held while beat_ready=0.
REQ-041 rst pulsed during beat 2 of a len=7 burst -> beat_valid=0 immediately, cmd_ready=1, and the next command starts at beat_idx 0.
